// File: rtl/implication_monitor.sv
`default_nettype none
// ============================================================================
// Module   : implication_monitor
// Purpose  : Run-time checker for "ante at edge N implies cons at edge
//            N+DELAY". Reports each pass/fail as a one-cycle pulse. Keeps
//            saturating tallies and a sticky error flag. Captures the cycle
//            index of the first failure.
// Revision : 1.0 - initial release
// ============================================================================
module implication_monitor #(
  parameter int DELAY = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             ante_i,
  input  logic             cons_i,
  output logic             pass_pulse_o,
  output logic             fail_pulse_o,
  output logic             fail_sticky_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] first_fail_cycle_o
);

  localparam logic [CNT_W-1:0] c_cnt_max = '1;
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  // Obligation shift register: bit k set means an antecedent was seen k+1
  // enabled edges ago. The MSB is the obligation due at this edge.
  logic [DELAY-1:0] ob_q, ob_d;
  logic [DELAY-1:0] w_ob_shift;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] ffc_q, ffc_d;
  logic             w_due;

  // Counters stop at all-ones so a long run never wraps back to small values.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == c_cnt_max) ? v : v + c_cnt_one;
  endfunction

  // Next obligation vector: shift in the current antecedent.
  if (DELAY == 1) begin : g_ob_single
    assign w_ob_shift = ante_i;
  end else begin : g_ob_chain
    assign w_ob_shift = {ob_q[DELAY-2:0], ante_i};
  end

  assign w_due = ob_q[DELAY-1];

  // Next-state logic: clr dominates, then enable gates all tracking/checking.
  always_comb begin
    ob_d        = ob_q;
    pass_d      = 1'b0;
    fail_d      = 1'b0;
    sticky_d    = sticky_q;
    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    ffc_d       = ffc_q;
    if (clr_i) begin
      ob_d        = '0;
      sticky_d    = 1'b0;
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      cycle_cnt_d = '0;
      ffc_d       = '0;
    end else if (en_i) begin
      ob_d        = w_ob_shift;
      cycle_cnt_d = sat_inc(cycle_cnt_q);
      if (w_due) begin
        if (cons_i) begin
          pass_d     = 1'b1;
          pass_cnt_d = sat_inc(pass_cnt_q);
        end else begin
          fail_d     = 1'b1;
          fail_cnt_d = sat_inc(fail_cnt_q);
          sticky_d   = 1'b1;
          // Only the first failure is captured, using the pre-increment index.
          if (!sticky_q) begin
            ffc_d = cycle_cnt_q;
          end
        end
      end
    end else begin
      // Disabling abandons outstanding obligations without judging them.
      ob_d = '0;
    end
  end

  // State registers; reset drops everything including pending obligations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_q        <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      sticky_q    <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
      cycle_cnt_q <= '0;
      ffc_q       <= '0;
    end else begin
      ob_q        <= ob_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      sticky_q    <= sticky_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      ffc_q       <= ffc_d;
    end
  end

  assign pass_pulse_o       = pass_q;
  assign fail_pulse_o       = fail_q;
  assign fail_sticky_o      = sticky_q;
  assign pending_o          = |ob_q;
  assign pass_cnt_o         = pass_cnt_q;
  assign fail_cnt_o         = fail_cnt_q;
  assign cycle_cnt_o        = cycle_cnt_q;
  assign first_fail_cycle_o = ffc_q;

endmodule
`default_nettype wire
